// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT output serializer.
// Frame size, sample width and FSM states live here.
package fft_pkg;

  localparam int N     = 4;
  localparam int W     = 2**N;
  localparam int NPT   = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/fft_scale_shift.sv
// Signed arithmetic right shift of one sample by a fixed amount.
// Sign-extending and truncating toward minus infinity.
module fft_scale_shift #(
  parameter int W     = 16,
  parameter int SCALE = 0
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = $signed(din) >>> SCALE;

endmodule

// File: rtl/fft_out_serializer.sv
// Captures one parallel 8-point FFT frame and streams it out
// one complex bin per beat, k = 0..7, over valid/ready.
module fft_out_serializer #(
  parameter  int N     = fft_pkg::N,
  parameter  int SCALE = 0,
  localparam int W     = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] y0,
  input  logic [W-1:0] y4,
  input  logic [W-1:0] yr1,
  input  logic [W-1:0] yi1,
  input  logic [W-1:0] yr2,
  input  logic [W-1:0] yi2,
  input  logic [W-1:0] yr3,
  input  logic [W-1:0] yi3,
  input  logic [W-1:0] yr5,
  input  logic [W-1:0] yi5,
  input  logic [W-1:0] yr6,
  input  logic [W-1:0] yi6,
  input  logic [W-1:0] yr7,
  input  logic [W-1:0] yi7,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic [2:0]   out_idx,
  output logic         out_last
);

  import fft_pkg::*;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d, k_nxt;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [W-1:0]     out_re_q, out_re_d;
  logic [W-1:0]     out_im_q, out_im_d;
  logic [W-1:0]     buf_re_q [NPT];
  logic [W-1:0]     buf_im_q [NPT];
  logic [W-1:0]     buf_re_d [NPT];
  logic [W-1:0]     buf_im_d [NPT];

  logic             in_fire, out_fire, load;
  logic [W-1:0]     src_re, src_im;
  logic [W-1:0]     sh_re, sh_im;

  fft_scale_shift #(.W(W), .SCALE(SCALE)) u_sh_re (
    .din  (src_re),
    .dout (sh_re)
  );

  fft_scale_shift #(.W(W), .SCALE(SCALE)) u_sh_im (
    .din  (src_im),
    .dout (sh_im)
  );

  // in_ready reopens combinationally on the last-beat fire,
  // which lets the next frame follow with no bubble.
  always_comb begin
    out_fire = out_valid_q && out_ready;
    in_ready = (state_q == IDLE) || (out_fire && out_last_q);
    in_fire  = in_valid && in_ready;
    k_nxt    = k_q + 3'd1;

    state_d     = state_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;
    src_re      = '0;
    src_im      = '0;
    load        = 1'b0;

    if (in_fire) begin
      buf_re_d = '{y0, yr1, yr2, yr3, y4, yr5, yr6, yr7};
      buf_im_d = '{'0, yi1, yi2, yi3, '0, yi5, yi6, yi7};
      state_d     = STREAM;
      k_d         = '0;
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      src_re      = y0;
      load        = 1'b1;
    end else if (out_fire) begin
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        k_d        = k_nxt;
        out_last_d = (k_nxt == 3'd7);
        src_re     = buf_re_q[k_nxt];
        src_im     = buf_im_q[k_nxt];
        load       = 1'b1;
      end
    end

    out_re_d = load ? sh_re : out_re_q;
    out_im_d = load ? sh_im : out_im_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_re_q <= buf_re_d;
    buf_im_q <= buf_im_d;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = k_q;

endmodule
